lbp_host: RTL and testbench

LBP_HOST -- requirements
Module: lbp_host

---
 rtl/lbp_host_if.sv | 36 +++
 rtl/lbp_host.sv | 102 ++++++++++
 tb/tb_lbp_host.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lbp_host_if.sv
// Bundle of the load, engine and result-dump signals between lbp_host and its neighbours.
// Pure wiring; the master side drives requests and the slave side is the host.
// Flow control: load_valid/load_ready and res_valid/res_ready handshakes.
interface lbp_host_if;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_ready;
  logic       eng_reset;
  logic       gray_req;
  logic [5:0] gray_addr;
  logic [7:0] gray_data;
  logic       lbp_write;
  logic [5:0] lbp_addr;
  logic [7:0] lbp_data;
  logic       finish;
  logic       res_valid;
  logic       res_ready;
  logic [5:0] res_addr;
  logic [7:0] res_data;
  logic       done;
  logic       err;

  modport master (
    output load_valid, load_data, gray_req, gray_addr,
           lbp_write, lbp_addr, lbp_data, finish, res_ready,
    input  load_ready, eng_reset, gray_data, res_valid,
           res_addr, res_data, done, err
  );

  modport slave (
    input  load_valid, load_data, gray_req, gray_addr,
           lbp_write, lbp_addr, lbp_data, finish, res_ready,
    output load_ready, eng_reset, gray_data, res_valid,
           res_addr, res_data, done, err
  );
endinterface

// File: rtl/lbp_host.sv
// LBP engine host: loads a 64-byte image, serves engine reads/writes, then dumps 64 results.
// Latency: gray_data 1 cycle after gray_req; res_data is combinational from res_addr.
// Backpressure: load always accepted in LOAD; dump address holds while res_ready=0.
// Optional RUN timeout enabled by defining LBP_HOST_TIMEOUT_EN.
module lbp_host (
  input  logic       clk,
  input  logic       reset,
  lbp_host_if.slave  bus
);

  typedef enum logic [1:0] {LOAD, RUN, DUMP, DONE} state_t;

  state_t     state;
  state_t     state_nxt;
  logic [5:0] load_cnt;
  logic [5:0] res_addr;
  logic [7:0] gray_data;
  logic       load_fire;
  logic       dump_fire;
  logic       tmo_hit;

  // Array contents survive reset by design, so they have no reset term.
  logic [7:0] gray_mem [64];
  logic [7:0] res_mem  [64];

  assign load_fire = (state == LOAD) && bus.load_valid;
  assign dump_fire = (state == DUMP) && bus.res_ready;

`ifdef LBP_HOST_TIMEOUT_EN
  logic [11:0] tmo_cnt;
  logic        err;

  // The counter reaches 4095 on the edge that ends the 4095th RUN cycle.
  assign tmo_hit = (state == RUN) && !bus.finish && (tmo_cnt == 12'd4094);

  // RUN-cycle counter, held at zero outside RUN so it starts clean on entry; err is sticky.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt <= 12'd0;
      err     <= 1'b0;
    end else begin
      if (state == RUN) tmo_cnt <= tmo_cnt + 12'd1;
      else              tmo_cnt <= 12'd0;
      if (tmo_hit) err <= 1'b1;
    end
  end

  assign bus.err = err;
`else
  assign tmo_hit = 1'b0;
  assign bus.err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= LOAD;
    else       state <= state_nxt;
  end

  // Next-state logic; finish wins over a same-cycle timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      LOAD: if (load_fire && (load_cnt == 6'd63)) state_nxt = RUN;
      RUN: begin
        if (bus.finish)   state_nxt = DUMP;
        else if (tmo_hit) state_nxt = DONE;
      end
      DUMP: if (dump_fire && (res_addr == 6'd63)) state_nxt = DONE;
      DONE: state_nxt = DONE;
      default: state_nxt = LOAD;
    endcase
  end

  // Load counter, dump address and registered gray read port; both counters stop at 63.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_cnt  <= 6'd0;
      res_addr  <= 6'd0;
      gray_data <= 8'd0;
    end else begin
      if (load_fire && (load_cnt != 6'd63)) load_cnt <= load_cnt + 6'd1;
      if (dump_fire && (res_addr != 6'd63)) res_addr <= res_addr + 6'd1;
      if ((state == RUN) && bus.gray_req) gray_data <= gray_mem[bus.gray_addr];
    end
  end

  // Array writes: image bytes during LOAD, engine results during RUN only.
  always_ff @(posedge clk) begin
    if (load_fire) gray_mem[load_cnt] <= bus.load_data;
    if ((state == RUN) && bus.lbp_write) res_mem[bus.lbp_addr] <= bus.lbp_data;
  end

  assign bus.load_ready = (state == LOAD);
  assign bus.eng_reset  = (state != RUN);
  assign bus.gray_data  = gray_data;
  assign bus.res_valid  = (state == DUMP);
  assign bus.res_addr   = res_addr;
  assign bus.res_data   = res_mem[res_addr];
  assign bus.done       = (state == DONE);

endmodule

// File: tb/tb_lbp_host.sv
// Testbench for lbp_host: image load, engine reads/writes, result dump with stall, resets.
// Inputs are driven on the falling edge; outputs are sampled on the falling edge.
// Expected dump bytes come from a local result model pushed into a scoreboard queue.
module tb_lbp_host;

  typedef struct packed {
    logic [5:0] addr;
    logic [7:0] data;
  } res_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  lbp_host_if bus ();

  lbp_host dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int         n_chk  = 0;
  int         n_pass = 0;
  res_t       exp_q [$];
  logic [7:0] gray_q [$];
  logic [7:0] res_mdl [64];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] pat(input int sess, input int i);
    logic [7:0] b;
    b = 8'(i);
    return (sess == 0) ? b : (b ^ 8'h5A);
  endfunction

  // Streams 64 bytes with load_valid held high; returns on the first RUN falling edge.
  task automatic load_image(input int sess);
    int acc;
    acc = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus.load_ready) acc++;
      bus.load_valid = 1'b1;
      bus.load_data  = pat(sess, i);
    end
    check("eng_reset_during_load", bus.eng_reset, 1);
    @(negedge clk);
    bus.load_valid = 1'b0;
    check("load_accepted", acc, 64);
    check("eng_reset_in_run", bus.eng_reset, 0);
    check("load_ready_in_run", bus.load_ready, 0);
  endtask

  // Issues back-to-back gray reads and compares each one a cycle later.
  task automatic gray_reads(input int sess);
    int addrs [5];
    addrs = '{9, 0, 63, 17, 42};
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (gray_q.size() > 0) check("gray_data", bus.gray_data, gray_q.pop_front());
      bus.gray_req  = 1'b1;
      bus.gray_addr = 6'(addrs[k]);
      gray_q.push_back(pat(sess, addrs[k]));
    end
    @(negedge clk);
    bus.gray_req  = 1'b0;
    bus.gray_addr = 6'd5;
    check("gray_data_last", bus.gray_data, gray_q.pop_front());
    @(negedge clk);
    check("gray_data_hold", bus.gray_data, pat(sess, 42));
  endtask

  task automatic eng_write(input int a, input logic [7:0] d, input logic fin);
    @(negedge clk);
    bus.lbp_write = 1'b1;
    bus.lbp_addr  = 6'(a);
    bus.lbp_data  = d;
    bus.finish    = fin;
    res_mdl[a]    = d;
  endtask

  task automatic push_expected();
    res_t e;
    for (int a = 0; a < 64; a++) begin
      e.addr = 6'(a);
      e.data = res_mdl[a];
      exp_q.push_back(e);
    end
  endtask

  // Called on a falling edge in DUMP; consumes nbytes from the scoreboard.
  task automatic dump_check(input int nbytes, input int stall_at);
    res_t e;
    bus.res_ready = 1'b1;
    for (int idx = 0; idx < nbytes; idx++) begin
      if (exp_q.size() == 0) begin
        check("scoreboard_underflow", 0, 1);
        break;
      end
      e = exp_q.pop_front();
      check("res_valid", bus.res_valid, 1);
      check("res_addr", bus.res_addr, e.addr);
      check("res_data", bus.res_data, e.data);
      if (idx == stall_at) begin
        bus.res_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check("stall_res_addr", bus.res_addr, e.addr);
          check("stall_res_data", bus.res_data, e.data);
        end
        bus.res_ready = 1'b1;
      end
      @(negedge clk);
    end
  endtask

  task automatic reset_now(input string tag);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check({tag, "_load_ready"}, bus.load_ready, 1);
    check({tag, "_eng_reset"}, bus.eng_reset, 1);
    check({tag, "_res_valid"}, bus.res_valid, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_err"}, bus.err, 0);
    check({tag, "_res_addr"}, bus.res_addr, 0);
    check({tag, "_gray_data"}, bus.gray_data, 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.load_valid = 1'b0;
    bus.load_data  = 8'd0;
    bus.gray_req   = 1'b0;
    bus.gray_addr  = 6'd0;
    bus.lbp_write  = 1'b0;
    bus.lbp_addr   = 6'd0;
    bus.lbp_data   = 8'd0;
    bus.finish     = 1'b0;
    bus.res_ready  = 1'b0;

    // Reset acts before any clock edge.
    #2 reset = 1'b1;
    #1;
    check("rst_load_ready", bus.load_ready, 1);
    check("rst_eng_reset", bus.eng_reset, 1);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_done", bus.done, 0);
    check("rst_err", bus.err, 0);
    check("rst_gray_data", bus.gray_data, 0);
    check("rst_res_addr", bus.res_addr, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Session 1: full load, reads, every result written, addr 9 overwritten.
    load_image(0);
    gray_reads(0);
    for (int a = 0; a < 64; a++) eng_write(a, 8'(a * 7 + 3), 1'b0);
    eng_write(9, 8'hA5, 1'b0);
    eng_write(63, 8'hC3, 1'b1);
    @(negedge clk);
    bus.lbp_write = 1'b0;
    bus.finish    = 1'b0;
    check("err_no_timeout", bus.err, 0);
    push_expected();
    dump_check(64, 3);
    check("done_after_dump", bus.done, 1);
    check("res_valid_in_done", bus.res_valid, 0);
    check("load_ready_in_done", bus.load_ready, 0);
    check("eng_reset_in_done", bus.eng_reset, 1);

    // Engine strobes in DONE must change nothing.
    @(negedge clk);
    bus.lbp_write = 1'b1;
    bus.lbp_addr  = 6'd5;
    bus.lbp_data  = 8'hEE;
    bus.gray_req  = 1'b1;
    bus.gray_addr = 6'd0;
    bus.finish    = 1'b1;
    repeat (3) @(negedge clk);
    check("done_sticky", bus.done, 1);
    check("gray_ignored_in_done", bus.gray_data, pat(0, 42));
    bus.lbp_write = 1'b0;
    bus.gray_req  = 1'b0;
    bus.finish    = 1'b0;

    // Session 2: reset from DONE, reload a new image, sparse writes, abort mid-dump.
    reset_now("rst_from_done");
    load_image(1);
    gray_reads(1);
    eng_write(2, 8'h11, 1'b0);
    eng_write(9, 8'h77, 1'b0);
    @(negedge clk);
    bus.lbp_write = 1'b0;
    bus.finish    = 1'b1;
    @(negedge clk);
    bus.finish = 1'b0;
    push_expected();
    dump_check(12, -1);
    reset_now("rst_mid_dump");
    exp_q.delete();

`ifdef LBP_HOST_TIMEOUT_EN
    begin
      int   n;
      logic saw_valid;
      load_image(0);
      n = 1;
      saw_valid = 1'b0;
      while (n < 5000) begin
        @(negedge clk);
        if (bus.res_valid) saw_valid = 1'b1;
        if (bus.eng_reset) break;
        n++;
      end
      check("timeout_run_cycles", n, 4095);
      check("timeout_err", bus.err, 1);
      check("timeout_done", bus.done, 1);
      check("timeout_no_res_valid", saw_valid, 0);
    end
`else
    begin
      load_image(0);
      repeat (4200) @(negedge clk);
      check("no_timeout_still_run", bus.eng_reset, 0);
      check("no_timeout_err", bus.err, 0);
      check("no_timeout_done", bus.done, 0);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
